// File: rtl/shift_left_seq.sv
// shift_left_seq: sequential left shifter / rotator.
//   Shifts the captured operand left by one bit position per clock, from 0 to WIDTH-1
//   places. The operand is either zero filled (logical) or rotated. A start/busy/done
//   handshake connects the block to the control unit.
// Ports:
//   clk    - system clock, rising edge active
//   rst    - synchronous, active-high reset
//   start  - request, sampled only in IDLE
//   X      - operand, captured when start is accepted
//   amt    - shift count 0..WIDTH-1, captured with X
//   rotate - 0 = logical shift left, 1 = rotate left, captured with X
//   busy   - high while an operation is in progress (state != IDLE)
//   done   - one-cycle pulse; Z, C and zf are valid in that cycle
//   Z      - result, held from done until the next accepted start
//   C      - last bit shifted out of the MSB (0 when amt = 0)
//   zf     - zero flag of the result
module shift_left_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [AMT_W-1:0] amt,
  input  logic             rotate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             C,
  output logic             zf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [AMT_W-1:0] AMT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  state_t           state_r;
  state_t           next_state_s;
  logic [AMT_W-1:0] count_r;
  logic             mode_r;
  logic [WIDTH-1:0] z_r;
  logic             c_r;
  logic             zf_r;
  logic [WIDTH-1:0] shifted_s;
  logic             last_shift_s;

  // One-position shift of the working value; the fill bit depends on the captured mode.
  always_comb begin
    shifted_s = {z_r[WIDTH-2:0], 1'b0};
    if (mode_r) begin
      shifted_s = {z_r[WIDTH-2:0], z_r[WIDTH-1]};
    end else begin
      shifted_s = {z_r[WIDTH-2:0], 1'b0};
    end
  end

  assign last_shift_s = (count_r == AMT_ONE);

  // Next-state logic for the IDLE -> SHIFT/DONE -> IDLE sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (amt == AMT_ZERO) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_SHIFT;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_shift_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath: operand capture in IDLE, one shift per edge in SHIFT, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_r     <= DATA_ZERO;
      c_r     <= 1'b0;
      zf_r    <= 1'b0;
      count_r <= AMT_ZERO;
      mode_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            z_r     <= X;
            c_r     <= 1'b0;
            count_r <= amt;
            mode_r  <= rotate;
            // A zero-length operation finishes immediately, so its flag is set now.
            if (amt == AMT_ZERO) begin
              zf_r <= (X == DATA_ZERO);
            end
          end
        end
        ST_SHIFT: begin
          z_r     <= shifted_s;
          c_r     <= z_r[WIDTH-1];
          count_r <= count_r - AMT_ONE;
          // The flag reflects the post-shift value of the final step.
          if (last_shift_s) begin
            zf_r <= (shifted_s == DATA_ZERO);
          end
        end
        ST_DONE: begin
          z_r <= z_r;
        end
        default: begin
          z_r <= z_r;
        end
      endcase
    end
  end

  assign busy = (state_r != ST_IDLE);
  assign done = (state_r == ST_DONE);
  assign Z    = z_r;
  assign C    = c_r;
  assign zf   = zf_r;

endmodule

// File: tb/tb_shift_left_seq.sv
// tb_shift_left_seq: directed self-checking bench for shift_left_seq.
//   Drives inputs on the falling edge and samples outputs on the falling edge,
//   away from the active rising edge. Expected values are hand computed.
module tb_shift_left_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] X;
  logic [2:0] amt;
  logic       rotate;
  logic       busy;
  logic       done;
  logic [7:0] Z;
  logic       C;
  logic       zf;

  int checks;
  int errors;

  shift_left_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .X      (X),
    .amt    (amt),
    .rotate (rotate),
    .busy   (busy),
    .done   (done),
    .Z      (Z),
    .C      (C),
    .zf     (zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for IDLE, issues one request and waits (bounded) for done.
  // edges counts rising edges from acceptance up to the one that raises done.
  task automatic run_op(input logic [7:0] x, input logic [2:0] a, input logic r,
                        output int edges, output bit timed_out);
    int guard;
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    start  = 1'b1;
    X      = x;
    amt    = a;
    rotate = r;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, Z, C, zf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_init: busy=%b done=%b Z=%h C=%b zf=%b expected all zero",
               busy, done, Z, C, zf);
    end
    // Abort a shift in progress: X=FF, amt=5, reset after two shifts.
    start = 1'b1; X = 8'hFF; amt = 3'd5; rotate = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || Z !== 8'hFC) begin
      errors++;
      $display("FAIL reset_midshift_pre: busy=%b Z=%h expected busy=1 Z=fc", busy, Z);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, Z, C, zf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_abort: busy=%b done=%b Z=%h C=%b zf=%b expected all zero",
               busy, done, Z, C, zf);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: cycle %0d done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_logical();
    int edges;
    bit to;
    run_op(8'h96, 3'd3, 1'b0, edges, to);
    checks++;
    if (to || edges !== 4) begin
      errors++;
      $display("FAIL logical_latency: edges=%0d timeout=%b expected 4", edges, to);
    end
    checks++;
    if ({Z, C, zf} !== {8'hB0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL logical_result: Z=%h C=%b zf=%b expected b0 0 0", Z, C, zf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL logical_pulse: done=%b busy=%b expected 0 0", done, busy);
    end
    // Logical shift where the carry is set: 4D << 5 = A0, C = X[3] = 1.
    run_op(8'h4D, 3'd5, 1'b0, edges, to);
    checks++;
    if (to || edges !== 6 || {Z, C, zf} !== {8'hA0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL logical_carry: edges=%0d Z=%h C=%b zf=%b expected 6 a0 1 0",
               edges, Z, C, zf);
    end
  endtask

  task automatic test_rotate();
    int edges;
    bit to;
    run_op(8'h81, 3'd1, 1'b1, edges, to);
    checks++;
    if (to || edges !== 2 || {Z, C, zf} !== {8'h03, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rotate_by1: edges=%0d Z=%h C=%b zf=%b expected 2 03 1 0",
               edges, Z, C, zf);
    end
    run_op(8'hA5, 3'd7, 1'b1, edges, to);
    checks++;
    if (to || edges !== 8 || {Z, C, zf} !== {8'hD2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rotate_by7: edges=%0d Z=%h C=%b zf=%b expected 8 d2 0 0",
               edges, Z, C, zf);
    end
  endtask

  task automatic test_zero_carry();
    int edges;
    bit to;
    run_op(8'h80, 3'd1, 1'b0, edges, to);
    checks++;
    if (to || edges !== 2 || {Z, C, zf} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL zero_shiftout: edges=%0d Z=%h C=%b zf=%b expected 2 00 1 1",
               edges, Z, C, zf);
    end
    run_op(8'h00, 3'd0, 1'b0, edges, to);
    checks++;
    if (to || edges !== 1 || {Z, C, zf} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL amt0_zero: edges=%0d Z=%h C=%b zf=%b expected 1 00 0 1",
               edges, Z, C, zf);
    end
    run_op(8'h5A, 3'd0, 1'b1, edges, to);
    checks++;
    if (to || edges !== 1 || {Z, C, zf} !== {8'h5A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL amt0_nonzero: edges=%0d Z=%h C=%b zf=%b expected 1 5a 0 0",
               edges, Z, C, zf);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    int guard;
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    // E1 rotl 3 = 0F, C = 1. A second request is presented while busy.
    start = 1'b1; X = 8'hE1; amt = 3'd3; rotate = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    X = 8'h01; amt = 3'd1; rotate = 1'b0;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checks++;
    if (!done || edges !== 4 || {Z, C, zf} !== {8'h0F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL busy_ignore: done=%b edges=%0d Z=%h C=%b zf=%b expected 1 4 0f 1 0",
               done, edges, Z, C, zf);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Z !== 8'h0F) begin
      errors++;
      $display("FAIL busy_drop: busy=%b done=%b Z=%h expected 0 0 0f", busy, done, Z);
    end
    // start is still high, so this IDLE cycle accepts 01 << 1.
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_start_accept: busy=%b expected 1", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || {Z, C, zf} !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL held_start_result: done=%b Z=%h C=%b zf=%b expected 1 02 0 0",
               done, Z, C, zf);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      X = 8'h11 * i[7:0];
      amt = i[2:0];
      rotate = i[0];
      @(negedge clk);
      checks++;
      if ({Z, C, zf, done, busy} !== {8'h02, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold: cycle %0d Z=%h C=%b zf=%b done=%b busy=%b expected 02 0 0 0 0",
                 i, Z, C, zf, done, busy);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    X = 8'h00;
    amt = 3'd0;
    rotate = 1'b0;
    @(negedge clk);
    test_reset();
    test_logical();
    test_rotate();
    test_zero_carry();
    test_back_to_back();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
